keypad_emu: RTL and testbench
=============================

Name: keypad_emu

Overview:
Behavioural 4x4 matrix-keypad emulator, synthesizable, for on-board loopback self-test of the Whack-a-mole key scanner.
- A host (test sequencer or debug UART bridge) issues press/release commands for a 4-bit key code over a valid/ready handshake.
- The block models contact bounce, then answers the scanner's one-hot column drive (c_pin) with the matching one-hot row level (r_pin).
- Single-key model: at most one key closed at a time.

Parameters:
BOUNCE_CYC, 2000, clk cycles per bounce phase (legal 1..65535).
BOUNCE_TOGGLES, 6, contact inversions per bounce burst before settling (legal 0..15).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  block can accept a command
cmd_key  in  4  key code 0..15
cmd_press  in  1  1 = press, 0 = release
c_pin  in  4  column drive from scanner, one-hot active-high
r_pin  out  4  row level to scanner, active-high, registered
key_down  out  1  key settled closed (HELD state)
busy  out  1  bounce burst in progress
contact  out  1  current modelled contact level (debug)

Behaviour:
- Reset (rst=0, async): state=IDLE; r_pin=0, contact=0, key_down=0, busy=0, cmd_ready=1; latched key=0; counters=0. Reset mid-bounce aborts immediately to these values.

Key map, code -> (column one-hot, row one-hot):
- Column 1000: 10->row 1000, 3->0100, 2->0010, 1->0001.
- Column 0100: 13->1000, 14->0100, 0->0010, 15->0001.
- Column 0010: 12->1000, 9->0100, 8->0010, 7->0001.
- Column 0001: 11->1000, 6->0100, 5->0010, 4->0001.

Row output:
- Each cycle, r_pin <= row_oh if (contact && (c_pin & col_oh) != 0), else 0.
- One-cycle latency from c_pin/contact to r_pin.
- c_pin not one-hot (0000 or multi-bit): respond per the AND rule above; no error.

Handshake:
- Transfer occurs when cmd_valid && cmd_ready.
- cmd_ready = 1 in IDLE and HELD; 0 in PRESS_BOUNCE and RELEASE_BOUNCE.
- busy = ~cmd_ready.

State machine (IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE):
- IDLE + press accepted: latch cmd_key; contact<=1; cyc_cnt<=0; tog_cnt<=0; go PRESS_BOUNCE.
- IDLE + release accepted: no-op; stay IDLE.
- PRESS_BOUNCE, each cycle: cyc_cnt++. When cyc_cnt==BOUNCE_CYC-1: cyc_cnt<=0; then
  - if tog_cnt==BOUNCE_TOGGLES: contact<=1, go HELD;
  - else contact<=~contact, tog_cnt++.
- HELD + release accepted: contact<=0, counters cleared, go RELEASE_BOUNCE.
- HELD + press accepted: consumed and ignored (any key code); latched key unchanged.
- RELEASE_BOUNCE: same counting as PRESS_BOUNCE, but the final forced level is contact<=0 and the exit is to IDLE.
- Burst duration is exactly (BOUNCE_TOGGLES+1)*BOUNCE_CYC cycles from the accept edge to the state change.
- BOUNCE_TOGGLES=0 gives a clean edge held for BOUNCE_CYC cycles.
- key_down = (state==HELD), registered with the state.

Widths:
- cyc_cnt is 16-bit; tog_cnt is 4-bit. Neither wraps, because both are compared and cleared.

Test Plan:
- BOUNCE_CYC=4, BOUNCE_TOGGLES=0; press key 5; drive c_pin=0001 -> after 4 cycles key_down=1; r_pin=0010 one cycle after c_pin applied; c_pin=1000 -> r_pin=0000.
- BOUNCE_CYC=4, BOUNCE_TOGGLES=6; press key 14 with c_pin=0100 held -> r_pin pattern 1,0,1,0,1,0,1,1 in 4-cycle phases; key_down rises at cycle 28; cmd_ready=0 throughout the burst.
- Sweep all 16 codes: press, cycle c_pin through all four columns, release -> r_pin nonzero only on the mapped column with the mapped row; after release settles, r_pin=0 and state=IDLE.
- Handshake: hold cmd_valid during a bounce burst -> not accepted until cmd_ready=1. Press in HELD -> ignored, key unchanged. Release in IDLE -> no effect.
- Loopback with key scanner at full timing: press 9, 8, 0 in turn -> scanner key_out = 9, 8, 0 respectively, each with o_key_out_en pulsing.
- Assert rst low mid PRESS_BOUNCE -> r_pin, contact, key_down and busy go 0 asynchronously; after release of rst, a new press works normally.

Source files
------------

// File: rtl/keypad_emu.sv
// Purpose: 4x4 matrix-keypad emulator with contact-bounce model for scanner loopback self-test.
// Latency: r_pin follows c_pin/contact one cycle later; a bounce burst lasts (BOUNCE_TOGGLES+1)*BOUNCE_CYC cycles.
// Backpressure: cmd_ready drops for the whole bounce burst; commands are only consumed in IDLE and HELD.
module keypad_emu #(
    parameter int BOUNCE_CYC     = 2000,
    parameter int BOUNCE_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_key,
    input  logic       cmd_press,
    input  logic [3:0] c_pin,
    output logic [3:0] r_pin,
    output logic       key_down,
    output logic       busy,
    output logic       contact
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_BOUNCE   = 2'd1,
        HELD           = 2'd2,
        RELEASE_BOUNCE = 2'd3
    } state_t;

    // Terminal counts; both counters are cleared on reaching these, so they never wrap.
    localparam logic [15:0] CYC_LAST = 16'(BOUNCE_CYC - 1);
    localparam logic [3:0]  TOG_LAST = 4'(BOUNCE_TOGGLES);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cyc_cnt;
    logic [15:0] cyc_nxt;
    logic [3:0]  tog_cnt;
    logic [3:0]  tog_nxt;
    logic [3:0]  key_q;
    logic [3:0]  key_nxt;
    logic        contact_nxt;
    logic [3:0]  col_oh;
    logic [3:0]  row_oh;
    logic        cmd_fire;

    assign cmd_ready = (state == IDLE) || (state == HELD);
    assign busy      = ~cmd_ready;
    assign key_down  = (state == HELD);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Key code to (column, row) position on the matrix.
    always_comb begin
        col_oh = 4'b0000;
        row_oh = 4'b0000;
        case (key_q)
            4'd10: begin col_oh = 4'b1000; row_oh = 4'b1000; end
            4'd3:  begin col_oh = 4'b1000; row_oh = 4'b0100; end
            4'd2:  begin col_oh = 4'b1000; row_oh = 4'b0010; end
            4'd1:  begin col_oh = 4'b1000; row_oh = 4'b0001; end
            4'd13: begin col_oh = 4'b0100; row_oh = 4'b1000; end
            4'd14: begin col_oh = 4'b0100; row_oh = 4'b0100; end
            4'd0:  begin col_oh = 4'b0100; row_oh = 4'b0010; end
            4'd15: begin col_oh = 4'b0100; row_oh = 4'b0001; end
            4'd12: begin col_oh = 4'b0010; row_oh = 4'b1000; end
            4'd9:  begin col_oh = 4'b0010; row_oh = 4'b0100; end
            4'd8:  begin col_oh = 4'b0010; row_oh = 4'b0010; end
            4'd7:  begin col_oh = 4'b0010; row_oh = 4'b0001; end
            4'd11: begin col_oh = 4'b0001; row_oh = 4'b1000; end
            4'd6:  begin col_oh = 4'b0001; row_oh = 4'b0100; end
            4'd5:  begin col_oh = 4'b0001; row_oh = 4'b0010; end
            4'd4:  begin col_oh = 4'b0001; row_oh = 4'b0001; end
        endcase
    end

    // Next-state logic: command acceptance and the bounce phase/toggle counting.
    always_comb begin
        state_nxt   = state;
        cyc_nxt     = cyc_cnt;
        tog_nxt     = tog_cnt;
        key_nxt     = key_q;
        contact_nxt = contact;
        case (state)
            IDLE: begin
                // A release with no key down is simply consumed.
                if (cmd_fire && cmd_press) begin
                    key_nxt     = cmd_key;
                    contact_nxt = 1'b1;
                    cyc_nxt     = 16'd0;
                    tog_nxt     = 4'd0;
                    state_nxt   = PRESS_BOUNCE;
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nxt = 16'd0;
                    if (tog_cnt == TOG_LAST) begin
                        // Settle to the level the command asked for.
                        contact_nxt = (state == PRESS_BOUNCE);
                        state_nxt   = (state == PRESS_BOUNCE) ? HELD : IDLE;
                    end else begin
                        contact_nxt = ~contact;
                        tog_nxt     = tog_cnt + 4'd1;
                    end
                end else begin
                    cyc_nxt = cyc_cnt + 16'd1;
                end
            end
            HELD: begin
                // Single-key model: a second press is consumed without effect.
                if (cmd_fire && !cmd_press) begin
                    contact_nxt = 1'b0;
                    cyc_nxt     = 16'd0;
                    tog_nxt     = 4'd0;
                    state_nxt   = RELEASE_BOUNCE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and latched-key registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cyc_cnt <= 16'd0;
            tog_cnt <= 4'd0;
            key_q   <= 4'd0;
            contact <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            tog_cnt <= tog_nxt;
            key_q   <= key_nxt;
            contact <= contact_nxt;
        end
    end

    // Row answer: drive the key's row only while its column is strobed and the contact is closed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pin <= 4'b0000;
        end else begin
            r_pin <= (contact && ((c_pin & col_oh) != 4'b0000)) ? row_oh : 4'b0000;
        end
    end

endmodule

// File: tb/tb_keypad_emu.sv
// Purpose: directed bench for keypad_emu with a queue-based scoreboard and negedge monitor.
// Latency: expectations are pushed just after a rising edge and consumed at the following falling edge.
// Backpressure: command valid is held through bursts to show it waits for cmd_ready.
module tb_keypad_emu;

    localparam int BC    = 4;
    localparam int BT    = 6;
    localparam int BURST = (BT + 1) * BC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_key = 4'd0;
    logic       cmd_press = 1'b0;
    logic [3:0] c_pin = 4'b0000;
    logic [3:0] r_pin;
    logic       key_down;
    logic       busy;
    logic       contact;

    keypad_emu #(.BOUNCE_CYC(BC), .BOUNCE_TOGGLES(BT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .cmd_press (cmd_press),
        .c_pin     (c_pin),
        .r_pin     (r_pin),
        .key_down  (key_down),
        .busy      (busy),
        .contact   (contact)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] r;
        logic       kd;
        logic       bsy;
        logic       ct;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] tcol[16];
    logic [3:0] trow[16];

    // Monitor: one expectation per falling edge when one is pending.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (r_pin !== mon_e.r || key_down !== mon_e.kd || busy !== mon_e.bsy ||
                cmd_ready !== ~mon_e.bsy || contact !== mon_e.ct) begin
                errors++;
                $display("FAIL %s: got r_pin=%b key_down=%b busy=%b cmd_ready=%b contact=%b, want r_pin=%b key_down=%b busy=%b cmd_ready=%b contact=%b",
                         mon_e.name, r_pin, key_down, busy, cmd_ready, contact,
                         mon_e.r, mon_e.kd, mon_e.bsy, ~mon_e.bsy, mon_e.ct);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] r, input logic kd,
                       input logic bsy, input logic ct);
        exp_t e;
        e.name = nm;
        e.r    = r;
        e.kd   = kd;
        e.bsy  = bsy;
        e.ct   = ct;
        sb.push_back(e);
    endtask

    // Called just after the accepting edge; checks every cycle through the settle edge.
    task automatic run_burst(input string nm, input bit is_press, input logic [3:0] row_exp);
        logic       c_prev;
        logic       c_now;
        logic       kd;
        logic [3:0] r;
        c_prev = is_press ? 1'b0 : 1'b1;
        for (int j = 0; j <= BURST; j++) begin
            if (j < BURST) c_now = (((j / BC) % 2) == 0) ? is_press : ~is_press;
            else           c_now = is_press;
            r  = c_prev ? row_exp : 4'b0000;
            kd = is_press && (j >= BURST);
            chk($sformatf("%s j=%0d", nm, j), r, kd, (j < BURST), c_now);
            c_prev = c_now;
            if (j < BURST) step();
        end
    endtask

    task automatic hold_chk(input string nm, input logic [3:0] cp, input logic [3:0] r);
        c_pin = cp;
        step();
        chk(nm, r, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [3:0] cv;
        tcol[0]  = 4'b0100; trow[0]  = 4'b0010;
        tcol[1]  = 4'b1000; trow[1]  = 4'b0001;
        tcol[2]  = 4'b1000; trow[2]  = 4'b0010;
        tcol[3]  = 4'b1000; trow[3]  = 4'b0100;
        tcol[4]  = 4'b0001; trow[4]  = 4'b0001;
        tcol[5]  = 4'b0001; trow[5]  = 4'b0010;
        tcol[6]  = 4'b0001; trow[6]  = 4'b0100;
        tcol[7]  = 4'b0010; trow[7]  = 4'b0001;
        tcol[8]  = 4'b0010; trow[8]  = 4'b0010;
        tcol[9]  = 4'b0010; trow[9]  = 4'b0100;
        tcol[10] = 4'b1000; trow[10] = 4'b1000;
        tcol[11] = 4'b0001; trow[11] = 4'b1000;
        tcol[12] = 4'b0010; trow[12] = 4'b1000;
        tcol[13] = 4'b0100; trow[13] = 4'b1000;
        tcol[14] = 4'b0100; trow[14] = 4'b0100;
        tcol[15] = 4'b0100; trow[15] = 4'b0001;

        // Reset state
        step();
        chk("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        chk("idle after reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();

        // Key 14 with its column strobed; a release is held pending through the press burst
        cmd_key = 4'd14; cmd_press = 1'b1; c_pin = 4'b0100; cmd_valid = 1'b1;
        chk("pre press14", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        cmd_press = 1'b0;
        run_burst("press14", 1'b1, 4'b0100);
        step();
        cmd_valid = 1'b0;
        run_burst("rel14", 1'b0, 4'b0100);
        step();
        chk("idle after rel14", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();

        // Key 5 held: column AND rule and one-cycle latency
        cmd_key = 4'd5; cmd_press = 1'b1; c_pin = 4'b0001; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        run_burst("press5", 1'b1, 4'b0010);
        step();
        c_pin = 4'b1000;
        chk("k5 c1000 same cycle", 4'b0010, 1'b1, 1'b0, 1'b1);
        step();
        chk("k5 c1000", 4'b0000, 1'b1, 1'b0, 1'b1);
        hold_chk("k5 c0000", 4'b0000, 4'b0000);
        hold_chk("k5 c1111", 4'b1111, 4'b0010);
        hold_chk("k5 c0011", 4'b0011, 4'b0010);
        hold_chk("k5 c0010", 4'b0010, 4'b0000);

        // Press while HELD is consumed but ignored
        cmd_key = 4'd10; cmd_press = 1'b1; cmd_valid = 1'b1; c_pin = 4'b1000;
        step();
        cmd_valid = 1'b0;
        chk("held press ignored", 4'b0000, 1'b1, 1'b0, 1'b1);
        hold_chk("held key still 5 c0001", 4'b0001, 4'b0010);
        hold_chk("held key not 10 c1000", 4'b1000, 4'b0000);

        c_pin = 4'b0001; cmd_press = 1'b0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        run_burst("rel5", 1'b0, 4'b0010);

        // Release in IDLE is a no-op
        step();
        cmd_key = 4'd3; cmd_press = 1'b0; cmd_valid = 1'b1;
        chk("idle pre release", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk("idle release noop", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        chk("idle release noop 2", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Sweep all key codes across all columns
        for (int k = 0; k < 16; k++) begin
            step();
            cmd_key = 4'(k); cmd_press = 1'b1; c_pin = 4'b0000; cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            run_burst($sformatf("sweep press k=%0d", k), 1'b1, 4'b0000);
            for (int c = 0; c < 4; c++) begin
                cv = 4'b0001 << c;
                hold_chk($sformatf("sweep k=%0d c=%b", k, cv), cv,
                         (tcol[k] == cv) ? trow[k] : 4'b0000);
            end
            c_pin = 4'b0000; cmd_press = 1'b0; cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            run_burst($sformatf("sweep rel k=%0d", k), 1'b0, 4'b0000);
            step();
            chk($sformatf("sweep idle k=%0d", k), 4'b0000, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a press burst
        step();
        cmd_key = 4'd5; cmd_press = 1'b1; c_pin = 4'b0001; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("rb j0", 4'b0000, 1'b0, 1'b1, 1'b1);
        step();
        chk("rb j1", 4'b0010, 1'b0, 1'b1, 1'b1);
        step();
        chk("async reset mid burst", 4'b0000, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        step();
        chk("held in reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        cmd_key = 4'd9; cmd_press = 1'b1; c_pin = 4'b0010; cmd_valid = 1'b1;
        chk("idle after second reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        run_burst("press9", 1'b1, 4'b0100);
        cmd_press = 1'b0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        run_burst("rel9", 1'b0, 4'b0100);
        step();
        chk("final idle", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        step();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
